// File: rtl/banked_regfile_pkg.sv
// Shared types for the banked register file: processor mode decode and the
// fixed architectural-to-physical register layout.
package regfile_pkg;

    typedef enum logic [2:0] {
        MODE_USR     = 3'd0,   // user and system share one bank
        MODE_FIQ     = 3'd1,
        MODE_IRQ     = 3'd2,
        MODE_SVC     = 3'd3,
        MODE_ABT     = 3'd4,
        MODE_UND     = 3'd5,
        MODE_ILLEGAL = 3'd6
    } mode_t;

    localparam logic [4:0] CPSR_USR = 5'b10000;
    localparam logic [4:0] CPSR_FIQ = 5'b10001;
    localparam logic [4:0] CPSR_IRQ = 5'b10010;
    localparam logic [4:0] CPSR_SVC = 5'b10011;
    localparam logic [4:0] CPSR_ABT = 5'b10111;
    localparam logic [4:0] CPSR_UND = 5'b11011;
    localparam logic [4:0] CPSR_SYS = 5'b11111;

    localparam logic [4:0] PHYS_PC      = 5'd15;
    localparam logic [4:0] PHYS_SVC_R13 = 5'd16;
    localparam logic [4:0] PHYS_ABT_R13 = 5'd18;
    localparam logic [4:0] PHYS_UND_R13 = 5'd20;
    localparam logic [4:0] PHYS_IRQ_R13 = 5'd22;
    localparam logic [4:0] PHYS_FIQ_R8  = 5'd24;
    localparam logic [4:0] PHYS_FIQ_R13 = 5'd29;
    localparam logic [4:0] PHYS_RZ      = 5'd31;

    function automatic mode_t to_mode(input logic [4:0] m);
        mode_t r;
        case (m)
            CPSR_USR, CPSR_SYS: r = MODE_USR;
            CPSR_FIQ:           r = MODE_FIQ;
            CPSR_IRQ:           r = MODE_IRQ;
            CPSR_SVC:           r = MODE_SVC;
            CPSR_ABT:           r = MODE_ABT;
            CPSR_UND:           r = MODE_UND;
            default:            r = MODE_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// Decode-side read bus and Writeback-side write bus of the banked register file.
interface banked_regfile_if #(
    parameter int WIDTH = 32,
    parameter int NREAD = 3
);
    logic [4:0]             ModeD;
    logic                   UserBankD;
    logic [NREAD*4-1:0]     RAD;
    logic [NREAD-1:0]       RzRD;
    logic [NREAD*WIDTH-1:0] RDD;
    logic [WIDTH-1:0]       PCPlus8D;
    logic                   WE3W;
    logic [3:0]             WA3W;
    logic                   RzWW;
    logic [4:0]             ModeW;
    logic                   UserBankW;
    logic [WIDTH-1:0]       WD3W;
    logic                   BadModeFlag;

    modport master (
        output ModeD, UserBankD, RAD, RzRD, PCPlus8D,
        output WE3W, WA3W, RzWW, ModeW, UserBankW, WD3W,
        input  RDD, BadModeFlag
    );

    modport slave (
        input  ModeD, UserBankD, RAD, RzRD, PCPlus8D,
        input  WE3W, WA3W, RzWW, ModeW, UserBankW, WD3W,
        output RDD, BadModeFlag
    );
endinterface

// File: rtl/banked_regfile_regmap.sv
// Maps an architectural register number to its physical slot for a given mode;
// R15 without Rz select is flagged as the PC path rather than a storage index.
module regmap
    import regfile_pkg::*;
#(
    parameter bit HAS_FIQ = 1'b1
) (
    input  mode_t      i_mode,
    input  logic       i_userbank,
    input  logic       i_rz,
    input  logic [3:0] i_addr,
    output logic [4:0] o_phys,
    output logic       o_is_pc
);

    function automatic logic [4:0] pick_r13_r14(input logic [3:0] a,
                                                input logic [4:0] p13,
                                                input logic [4:0] dflt);
        logic [4:0] r;
        if (a == 4'd13)
            r = p13;
        else if (a == 4'd14)
            r = p13 + 5'd1;
        else
            r = dflt;
        return r;
    endfunction

    logic [4:0] w_user_phys;
    assign w_user_phys = {1'b0, i_addr};

    always_comb begin
        o_phys  = w_user_phys;
        o_is_pc = 1'b0;
        if (i_addr == 4'hF) begin
            if (i_rz)
                o_phys = PHYS_RZ;
            else
                o_is_pc = 1'b1;
        end else if (!i_userbank) begin
            // Illegal modes fall through to the user bank.
            case (i_mode)
                MODE_FIQ: begin
                    if (HAS_FIQ) begin
                        if (i_addr >= 4'd8)
                            o_phys = PHYS_FIQ_R8 | {2'b00, i_addr[2:0]};
                    end else begin
                        o_phys = pick_r13_r14(i_addr, PHYS_FIQ_R13, w_user_phys);
                    end
                end
                MODE_IRQ: o_phys = pick_r13_r14(i_addr, PHYS_IRQ_R13, w_user_phys);
                MODE_SVC: o_phys = pick_r13_r14(i_addr, PHYS_SVC_R13, w_user_phys);
                MODE_ABT: o_phys = pick_r13_r14(i_addr, PHYS_ABT_R13, w_user_phys);
                MODE_UND: o_phys = pick_r13_r14(i_addr, PHYS_UND_R13, w_user_phys);
                default:  o_phys = w_user_phys;
            endcase
        end
    end

endmodule

// File: rtl/banked_regfile.sv
// Banked ARM register file: NREAD combinational read ports with write-through
// bypass on physical index, one write port, Rz shadow register, bad-mode flag.
module banked_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREAD   = 3,
    parameter bit HAS_FIQ = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    banked_regfile_if.slave  bus
);

    localparam int NMAP = NREAD + 1;   // last mapper serves the write port

    mode_t      w_mode    [NMAP];
    logic       w_ub      [NMAP];
    logic       w_rz      [NMAP];
    logic [3:0] w_addr    [NMAP];
    logic [4:0] w_phys    [NMAP];
    logic       w_is_pc   [NMAP];

    logic [WIDTH-1:0] r_mem [32];
    logic             r_bad_mode;

    logic [4:0] w_wr_phys;
    logic       w_wr_valid;
    logic       w_bad_mode_set;

    genvar gi;
    generate
        for (gi = 0; gi < NMAP; gi++) begin : g_map
            if (gi < NREAD) begin : g_rd
                assign w_mode[gi] = to_mode(bus.ModeD);
                assign w_ub[gi]   = bus.UserBankD;
                assign w_rz[gi]   = bus.RzRD[gi];
                assign w_addr[gi] = bus.RAD[gi*4 +: 4];
            end else begin : g_wr
                assign w_mode[gi] = to_mode(bus.ModeW);
                assign w_ub[gi]   = bus.UserBankW;
                assign w_rz[gi]   = bus.RzWW;
                assign w_addr[gi] = bus.WA3W;
            end

            regmap #(
                .HAS_FIQ (HAS_FIQ)
            ) u_regmap (
                .i_mode     (w_mode[gi]),
                .i_userbank (w_ub[gi]),
                .i_rz       (w_rz[gi]),
                .i_addr     (w_addr[gi]),
                .o_phys     (w_phys[gi]),
                .o_is_pc    (w_is_pc[gi])
            );
        end
    endgenerate

    // R15 writes without Rz belong to fetch and are silently dropped.
    assign w_wr_phys      = w_phys[NREAD];
    assign w_wr_valid     = bus.WE3W && !w_is_pc[NREAD] && (w_wr_phys != PHYS_PC);
    assign w_bad_mode_set = bus.WE3W && !bus.UserBankW &&
                            (to_mode(bus.ModeW) == MODE_ILLEGAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_mem[i] <= '0;
            r_bad_mode <= 1'b0;
        end else begin
            if (w_wr_valid)
                r_mem[w_wr_phys] <= bus.WD3W;
            if (w_bad_mode_set)
                r_bad_mode <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd_data
            logic w_bypass;
            assign w_bypass = w_wr_valid && !reset && (w_wr_phys == w_phys[gi]);
            assign bus.RDD[gi*WIDTH +: WIDTH] = w_is_pc[gi] ? bus.PCPlus8D :
                                                w_bypass    ? bus.WD3W     :
                                                              r_mem[w_phys[gi]];
        end
    endgenerate

    assign bus.BadModeFlag = r_bad_mode;

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile: one instance with FIQ banking, one without,
// both fed the same stimulus.
module tb_banked_regfile;
    import regfile_pkg::*;

    localparam int W  = 32;
    localparam int NR = 3;

    logic clk;
    logic reset;

    banked_regfile_if #(.WIDTH(W), .NREAD(NR)) ifa ();
    banked_regfile_if #(.WIDTH(W), .NREAD(NR)) ifb ();

    assign ifb.ModeD     = ifa.ModeD;
    assign ifb.UserBankD = ifa.UserBankD;
    assign ifb.RAD       = ifa.RAD;
    assign ifb.RzRD      = ifa.RzRD;
    assign ifb.PCPlus8D  = ifa.PCPlus8D;
    assign ifb.WE3W      = ifa.WE3W;
    assign ifb.WA3W      = ifa.WA3W;
    assign ifb.RzWW      = ifa.RzWW;
    assign ifb.ModeW     = ifa.ModeW;
    assign ifb.UserBankW = ifa.UserBankW;
    assign ifb.WD3W      = ifa.WD3W;

    banked_regfile #(.WIDTH(W), .NREAD(NR), .HAS_FIQ(1'b1)) u_dut_fiq (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    banked_regfile #(.WIDTH(W), .NREAD(NR), .HAS_FIQ(1'b0)) u_dut_nofiq (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got,
                            input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [3:0] a, input logic rz);
        ifa.RAD[p*4 +: 4] = a;
        ifa.RzRD[p]       = rz;
    endtask

    function automatic logic [W-1:0] rda(input int p);
        return ifa.RDD[p*W +: W];
    endfunction

    function automatic logic [W-1:0] rdb(input int p);
        return ifb.RDD[p*W +: W];
    endfunction

    task automatic put_wr(input logic [4:0] m, input logic [3:0] a, input logic rz,
                          input logic ub, input logic [W-1:0] d);
        ifa.WE3W = 1'b1; ifa.ModeW = m; ifa.WA3W = a;
        ifa.RzWW = rz;   ifa.UserBankW = ub; ifa.WD3W = d;
    endtask

    task automatic end_wr();
        ifa.WE3W = 1'b0; ifa.RzWW = 1'b0; ifa.UserBankW = 1'b0;
    endtask

    // Write one register and return with the write deasserted.
    task automatic do_wr(input logic [4:0] m, input logic [3:0] a, input logic rz,
                         input logic ub, input logic [W-1:0] d);
        put_wr(m, a, rz, ub, d);
        tick();
        end_wr();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ifa.ModeD = CPSR_USR; ifa.UserBankD = 1'b0;
        ifa.RAD = '0; ifa.RzRD = '0; ifa.PCPlus8D = 32'h0000_0108;
        ifa.WE3W = 1'b0; ifa.WA3W = '0; ifa.RzWW = 1'b0;
        ifa.ModeW = CPSR_USR; ifa.UserBankW = 1'b0; ifa.WD3W = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("reset_flag", {31'd0, ifa.BadModeFlag}, 32'd0);
        check_eq("reset_r0", rda(0), 32'd0);

        // SVC R13 write; a user R13 read in the same cycle must not bypass.
        put_wr(CPSR_SVC, 4'd13, 1'b0, 1'b0, 32'hA5A5_0001);
        ifa.ModeD = CPSR_USR; set_rd(0, 4'd13, 1'b0);
        #1;
        check_eq("usr_r13_no_bypass", rda(0), 32'd0);
        tick(); end_wr(); #1;
        check_eq("usr_r13_after_svc_wr", rda(0), 32'd0);
        ifa.ModeD = CPSR_SVC; #1;
        check_eq("svc_r13", rda(0), 32'hA5A5_0001);

        // FIQ R8: banked with HAS_FIQ=1, shared with user otherwise.
        do_wr(CPSR_FIQ, 4'd8, 1'b0, 1'b0, 32'h0000_0F08);
        ifa.ModeD = CPSR_FIQ; set_rd(0, 4'd8, 1'b0); #1;
        check_eq("fiq_r8_fiq", rda(0), 32'h0000_0F08);
        check_eq("fiq_r8_nofiq", rdb(0), 32'h0000_0F08);
        ifa.ModeD = CPSR_USR; #1;
        check_eq("usr_r8_fiq", rda(0), 32'd0);
        check_eq("usr_r8_nofiq", rdb(0), 32'h0000_0F08);

        // IRQ R14 same-cycle bypass; UND R14 is another physical slot.
        put_wr(CPSR_IRQ, 4'd14, 1'b0, 1'b0, 32'hDEAD_BEEF);
        ifa.ModeD = CPSR_IRQ; set_rd(0, 4'd14, 1'b0); set_rd(1, 4'd14, 1'b0); #1;
        check_eq("irq_r14_bypass", rda(0), 32'hDEAD_BEEF);
        ifa.ModeD = CPSR_UND; #1;
        check_eq("und_r14_no_bypass", rda(1), 32'd0);
        tick(); end_wr();
        ifa.ModeD = CPSR_IRQ; #1;
        check_eq("irq_r14_stored", rda(1), 32'hDEAD_BEEF);

        // Rz write and PC-path reads.
        do_wr(CPSR_USR, 4'hF, 1'b1, 1'b0, 32'h0000_1234);
        set_rd(0, 4'hF, 1'b0); set_rd(1, 4'hF, 1'b1); set_rd(2, 4'hF, 1'b1); #1;
        check_eq("rz_port2", rda(2), 32'h0000_1234);
        check_eq("rz_port1", rda(1), 32'h0000_1234);
        check_eq("pc_port0", rda(0), 32'h0000_0108);
        do_wr(CPSR_USR, 4'hF, 1'b0, 1'b0, 32'hFFFF_FFFF);
        check_eq("r15_wr_dropped", rda(2), 32'h0000_1234);

        // UserBank overrides.
        do_wr(CPSR_SYS, 4'd13, 1'b0, 1'b0, 32'h0000_7000);
        ifa.ModeD = CPSR_SVC; ifa.UserBankD = 1'b1; set_rd(0, 4'd13, 1'b0); #1;
        check_eq("ubd_svc_r13", rda(0), 32'h0000_7000);
        check_eq("ubd_rz", rda(2), 32'h0000_1234);
        ifa.UserBankD = 1'b0; #1;
        check_eq("svc_r13_again", rda(0), 32'hA5A5_0001);
        do_wr(CPSR_ABT, 4'd14, 1'b0, 1'b1, 32'h0000_0ABC);
        ifa.ModeD = CPSR_USR; set_rd(0, 4'd14, 1'b0); #1;
        check_eq("ubw_usr_r14", rda(0), 32'h0000_0ABC);
        ifa.ModeD = CPSR_ABT; #1;
        check_eq("ubw_abt_r14", rda(0), 32'd0);
        do_wr(5'b00101, 4'd1, 1'b0, 1'b1, 32'h0000_0011);
        check_eq("ubw_illegal_no_flag", {31'd0, ifa.BadModeFlag}, 32'd0);

        // Illegal write mode: flag is sticky, data goes to the user bank.
        do_wr(5'b00101, 4'd13, 1'b0, 1'b0, 32'h0000_BAD0);
        check_eq("bad_flag_set", {31'd0, ifa.BadModeFlag}, 32'd1);
        check_eq("bad_flag_set_nofiq", {31'd0, ifb.BadModeFlag}, 32'd1);
        ifa.ModeD = CPSR_USR; set_rd(0, 4'd13, 1'b0); #1;
        check_eq("bad_wr_usr_r13", rda(0), 32'h0000_BAD0);
        ifa.ModeD = CPSR_SVC; #1;
        check_eq("bad_wr_svc_r13", rda(0), 32'hA5A5_0001);
        tick(); tick(); tick();
        check_eq("bad_flag_hold", {31'd0, ifa.BadModeFlag}, 32'd1);

        // Reset with a concurrent write: no bypass, nothing stored.
        reset = 1'b1;
        put_wr(CPSR_USR, 4'd2, 1'b0, 1'b0, 32'h0000_2222);
        ifa.ModeD = CPSR_USR; set_rd(0, 4'd2, 1'b0); #1;
        check_eq("rst_no_bypass", rda(0), 32'd0);
        tick();
        reset = 1'b0; end_wr();
        set_rd(1, 4'd13, 1'b0); set_rd(2, 4'hF, 1'b1); #1;
        check_eq("rst_flag_clr", {31'd0, ifa.BadModeFlag}, 32'd0);
        check_eq("rst_r2", rda(0), 32'd0);
        check_eq("rst_usr_r13", rda(1), 32'd0);
        check_eq("rst_rz", rda(2), 32'd0);
        ifa.ModeD = CPSR_SVC; #1;
        check_eq("rst_svc_r13", rda(1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised banked ARM register file: maps 4-bit architectural register numbers to physical registers using the current processor mode, and holds the physical register storage.
- Provides NREAD read ports, one write port, the micro-op shadow register Rz, and a user-bank override for LDM/STM with the ^ bit.
- Sits in the Decode stage of leg_pipelined; the write port is driven from Writeback.

Parameters:
- WIDTH, 32, data width of every register and port.
- NREAD, 3, number of read ports (minimum 1).
- HAS_FIQ, 1, 1 = R8–R14 are banked in FIQ mode; 0 = FIQ uses the user R8–R12 and banks only R13/R14 (as IRQ does, into the FIQ slots 29/30).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ModeD  in  5  CPSR[4:0] used for decoding the read ports.
- UserBankD  in  1  force user-mode mapping on all read ports.
- RAD  in  NREAD*4  architectural read addresses; port i is bits [4i+3:4i].
- RzRD  in  NREAD  per-port Rz select; honoured only when that port's address is 4'hF.
- RDD  out  NREAD*WIDTH  read data.
- PCPlus8D  in  WIDTH  value returned for R15 reads.
- WE3W  in  1  write enable.
- WA3W  in  4  architectural write address.
- RzWW  in  1  Rz write select; honoured only when WA3W = 4'hF.
- ModeW  in  5  mode used to decode the write address.
- UserBankW  in  1  force user mapping on the write port.
- WD3W  in  WIDTH  write data.
- BadModeFlag  out  1  sticky flag: a write was decoded with an illegal mode.

Behaviour:
- Physical map, fixed:
  - 0–15 = R0–R15 user/system.
  - 16/17 = SVC R13/R14.
  - 18/19 = ABT R13/R14.
  - 20/21 = UND R13/R14.
  - 22/23 = IRQ R13/R14.
  - 24–30 = FIQ R8–R14.
  - 31 = Rz.
- Mode codes:
  - 10000 user and 11111 system → user bank.
  - 10001 FIQ, 10010 IRQ, 10011 SVC, 10111 ABT, 11011 UND.
  - Any other code is illegal and decodes as user.
- UserBank forces the user bank regardless of mode. It has no effect on Rz or R15.
- Decode for architectural address a:
  - a = 15 with Rz select → physical 31.
  - a = 15 without Rz select → the PC path (no storage read).
  - Otherwise map a through the mode as above.
- Reads (combinational):
  - R15 returns PCPlus8D.
  - All other addresses return storage, with write-through bypass: if WE3W is high and the write's physical index equals the port's physical index, RDD returns WD3W in the same cycle.
  - Bypass compares physical indices, not architectural ones. Example: a SVC-mode read of R13 does not bypass a user-mode write to R13.
- Write (posedge clk, when WE3W = 1 and reset = 0):
  - Storage[phys] <= WD3W.
  - A write to R15 without Rz is dropped (the PC register is owned by the fetch stage).
  - Physical 15 is never written.
- BadModeFlag:
  - Set on the clock edge where WE3W = 1, UserBankW = 0, and ModeW is illegal. The write still occurs, to the user bank.
  - Cleared only by reset.
- Reset:
  - All 32 storage entries clear to 0 and BadModeFlag clears to 0 on the edge where reset is high.
  - A write presented in the same cycle as reset is discarded.
  - During reset, reads return combinational values from storage/bypass. Bypass is suppressed while reset is high.
- Simultaneous events:
  - Any number of read ports may address the same register; all see identical data.
  - A read and a write to different banks of the same architectural number are independent.
- Latency:
  - Read: 0 cycles.
  - Write: visible to reads through bypass in the same cycle, and from storage in the next cycle.
- Widths:
  - RDD, RAD and RzRD are packed vectors with port 0 in the LSBs.
  - The physical index is 5 bits.

Decomposition:
- Package regfile_pkg:
  - mode_t enum with the six legal modes plus ILLEGAL.
  - Physical index localparams (PHYS_SVC_R13 = 16, ..., PHYS_RZ = 31).
  - function to_mode(logic [4:0]) returning mode_t.
- Sub-module regmap:
  - Combinational: {mode_t, userbank, rz, addr[3:0]} → {phys[4:0], is_pc}.
  - Instantiated NREAD+1 times via generate.
  - Replaces the 32-bit one-hot decoders; a one-hot form, where needed, is 1 << phys.
- Storage, bypass and the flag live in the top module.

Test Plan:
- Reset, then SVC write R13 = 32'hA5A5_0001; user-mode read R13 → 0 and SVC-mode read R13 → A5A5_0001 next cycle.
- FIQ (HAS_FIQ = 1) write R8 = 32'h0000_0F08 → FIQ read R8 = 0F08, user read R8 = 0. Rerun with HAS_FIQ = 0 → user read R8 = 0F08.
- Same-cycle write IRQ R14 = 32'hDEAD_BEEF with IRQ read of R14 on port 0 → DEADBEEF that cycle. Port 1 reading UND R14 → 0 (no bypass).
- Rz: write with RzWW = 1, WA3W = 15, data 32'h1234 → read port 2 with RzRD[2] = 1, RA = 15 returns 1234. Port 0 with RA = 15, no Rz, returns PCPlus8D = 32'h0000_0108.
- UserBankD = 1 in SVC reads user R13 = 32'h0000_7000 (previously written in system mode 11111). UserBankW = 1 in ABT writes user R14, and the ABT R14 slot stays unchanged.
- Write with ModeW = 5'b00101 → BadModeFlag = 1 next cycle and user R-index written. Flag holds until reset. A write asserted in the same cycle as reset is not stored and all reads return 0 afterwards.
